uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Receive-path controller for the UART RX. It sequences the edge/bit counter by driving its enable and latched configuration, and consumes `edge_cnt`, `bit_cnt` and `edge_max` back from it. Around that counter it performs start detection, 3-sample majority voting, LSB-first deserialization, and parity and stop checking. It presents each good frame as `p_data` with a one-cycle `data_valid` strobe to the RX-side synchronizer of the multi-clock system.

## Interface
- `DATA_WIDTH`, 8, payload bits per frame.
- `MAX_PRESCALE`, 32, largest oversampling ratio.
- `PRSC_WIDTH`, $clog2(MAX_PRESCALE)+1, width of `prescale`.
- `FRAME_WIDTH`, $clog2(DATA_WIDTH+3)+1, counter frame width; `bit_cnt` is FRAME_WIDTH-1 bits.

Ports:
- `clk`, in, 1, RX oversampling clock.
- `rst`, in, 1, reset: asynchronous, active-low.
- `rx_in`, in, 1, serial line, already synchronized upstream; idle high.
- `cfg_prescale`, in, PRSC_WIDTH, oversampling ratio; legal values are 8, 16, 32.
- `cfg_par_en`, in, 1, parity bit present.
- `cfg_par_typ`, in, 1, 0 = even, 1 = odd.
- `edge_cnt`, in, PRSC_WIDTH-1, from the counter.
- `bit_cnt`, in, FRAME_WIDTH-1, from the counter.
- `edge_max`, in, 1, from the counter: last oversample of the current bit.
- `cnt_enable`, out, 1, counter enable.
- `cnt_prescale`, out, PRSC_WIDTH, latched prescale, driven to the counter.
- `cnt_par_en`, out, 1, latched parity enable, driven to the counter.
- `p_data`, out, DATA_WIDTH, last good payload.
- `data_valid`, out, 1, one-cycle strobe marking a good frame.
- `par_err`, out, 1, parity error flag for the last frame.
- `stp_err`, out, 1, stop error flag for the last frame.
- `rx_busy`, out, 1, high whenever state ≠ IDLE.

## Operation
- **Reset:** state = IDLE. All outputs are 0, the shift register is 0, and the latched configuration is {prescale 8, par_en 0, par_typ 0}.
- `cnt_enable` = `rx_busy` = (state ≠ IDLE), decoded from the state register. Deasserting it clears the counter on the next clock.
- **Configuration latch:** `cfg_*` is latched on the IDLE→START edge and held for the whole frame. A `cfg_prescale` value other than 8/16/32 latches as 8. Changing `cfg_*` mid-frame has no effect.
- **Sampling, with P = latched prescale:**
  - s0 is registered at `edge_cnt` = P/2-1 and s1 at `edge_cnt` = P/2.
  - At `edge_cnt` = P/2+1, `sampled_bit` <= majority(s0, s1, `rx_in`).
  - The `sample_valid` strobe is registered high for exactly the cycle with `edge_cnt` = P/2+2.
  - All decisions below take effect on the clock edge that ends the `sample_valid` cycle.

State machine:
- **IDLE:** if `rx_in` = 0, go to START. On this same edge, clear `par_err` and `stp_err` and latch the configuration.
- **START:**
  - At `sample_valid`: if `sampled_bit` = 1, it is a glitch; go to IDLE, with no flags and no strobe.
  - Otherwise, on `edge_max` with `bit_cnt` = 0, go to DATA.
- **DATA:**
  - At `sample_valid`: shift = {`sampled_bit`, shift[DATA_WIDTH-1:1]} (LSB first).
  - On `edge_max` with `bit_cnt` = DATA_WIDTH: go to PARITY if par_en, else STOP.
- **PARITY:**
  - At `sample_valid`: `par_err` <= `sampled_bit` ≠ (^shift ^ par_typ).
  - On `edge_max`: go to STOP.
- **STOP:** at `sample_valid`:
  - `stp_err` <= ~`sampled_bit`.
  - If there is no parity error and `sampled_bit` = 1: `p_data` <= shift, and `data_valid` = 1 for the next cycle only.
  - Go to IDLE on the same edge. This mid-stop exit lets back-to-back frames be caught.
- **Bad frames:** an errored frame leaves `p_data` unchanged and produces no `data_valid`. `par_err` and `stp_err` hold until the next IDLE→START.

## Timing
- **Cycle numbering:** E0 is the edge at which the state becomes START. Cycle n is the interval after edge En. In cycle n, `edge_cnt` = n mod P and `bit_cnt` = n div P.
- The stop-bit `sample_valid` falls in cycle n_s = F·P + P/2 + 2, where F = 9 without parity and F = 10 with parity.
- `data_valid`, `par_err` and `stp_err` update at edge E(n_s+1):
  - P = 16, no parity: E155.
  - P = 16, parity: E171.
- IDLE is re-entered at the same edge E(n_s+1). The earliest next start can be detected at E(n_s+2).
- A glitch aborts at edge E(P/2+3). The counter is cleared one clock later.
- **Asynchronous reset mid-frame:** immediate IDLE with all outputs 0. No `data_valid` is produced for the interrupted frame.
- Simultaneous `rx_in` = 0 and a `data_valid` cycle are both legal. The frame completes and the new start is honored.

## Test plan
- **Good frame:** P = 16, no parity, byte 0xA5 LSB first with stop = 1 -> `data_valid` high for one cycle at E155, `p_data` = 0xA5, both error flags 0.
- **Even parity:** P = 8, even parity, 0x3C with parity bit 0 -> `p_data` = 0x3C, `data_valid` at E10·8+7 = E87. Repeat with parity bit 1 -> `par_err` = 1, no `data_valid`, `p_data` still 0x3C.
- **Stop error:** P = 32, stop bit driven 0 on 0x81 -> `stp_err` = 1, no `data_valid`. The next good frame clears `stp_err` at its start and delivers its byte.
- **Start glitch:** P = 16, `rx_in` low for 4 clocks then high -> return to IDLE at E11, `cnt_enable` = 0, no flags, no strobe.
- **Back-to-back and config latch:** 0x55 then 0xAA with no idle gap, and `cfg_par_en` toggled mid-frame -> two `data_valid` pulses with the correct bytes, and `cnt_par_en` constant within each frame.
- **Reset mid-frame:** `rst` asserted mid-DATA -> all outputs 0 immediately. A subsequent frame 0x0F is received correctly.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------------------------
// uart_rx_ctrl
//
// Receive-path controller for the UART RX. Drives the external edge/bit counter (enable plus the
// configuration latched for the current frame) and consumes its edge_cnt / bit_cnt / edge_max.
// Around that counter it detects the start bit, takes a 3-sample majority vote near the middle
// of every bit, deserializes LSB first, checks parity and stop, and presents each good frame as
// p_data with a one-cycle data_valid strobe.
//
// Ports:
//   clk           RX oversampling clock
//   rst           asynchronous, active-low reset
//   rx_in         serial line (already synchronized, idle high)
//   cfg_prescale  oversampling ratio (8/16/32; anything else is taken as 8)
//   cfg_par_en    parity bit present
//   cfg_par_typ   0 = even, 1 = odd
//   edge_cnt      oversample index within the current bit (from the counter)
//   bit_cnt       bit index within the frame (from the counter)
//   edge_max      last oversample of the current bit (from the counter)
//   cnt_enable    counter enable; low clears the counter on the next clock
//   cnt_prescale  latched prescale for the counter
//   cnt_par_en    latched parity enable for the counter
//   p_data        last good payload
//   data_valid    one-cycle strobe marking a good frame
//   par_err       parity error of the last frame
//   stp_err       stop error of the last frame
//   rx_busy       high whenever the controller is not idle
// ---------------------------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned MAX_PRESCALE = 32,
    parameter int unsigned PRSC_WIDTH   = $clog2(MAX_PRESCALE) + 1,
    parameter int unsigned FRAME_WIDTH  = $clog2(DATA_WIDTH + 3) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_in,
    input  logic [PRSC_WIDTH-1:0]  cfg_prescale,
    input  logic                   cfg_par_en,
    input  logic                   cfg_par_typ,
    input  logic [PRSC_WIDTH-2:0]  edge_cnt,
    input  logic [FRAME_WIDTH-2:0] bit_cnt,
    input  logic                   edge_max,
    output logic                   cnt_enable,
    output logic [PRSC_WIDTH-1:0]  cnt_prescale,
    output logic                   cnt_par_en,
    output logic [DATA_WIDTH-1:0]  p_data,
    output logic                   data_valid,
    output logic                   par_err,
    output logic                   stp_err,
    output logic                   rx_busy
);

    // -----------------------------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------------------------
    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    localparam logic [PRSC_WIDTH-1:0]  Presc8     = PRSC_WIDTH'(8);
    localparam logic [PRSC_WIDTH-1:0]  Presc16    = PRSC_WIDTH'(16);
    localparam logic [PRSC_WIDTH-1:0]  Presc32    = PRSC_WIDTH'(32);
    localparam logic [FRAME_WIDTH-2:0] BitCntLast = (FRAME_WIDTH - 1)'(DATA_WIDTH);

    // -----------------------------------------------------------------------------------------
    // State and registers
    // -----------------------------------------------------------------------------------------
    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic [PRSC_WIDTH-1:0] prescale_q, prescale_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;

    // Sampler
    logic s0_q;
    logic s1_q;
    logic sampled_bit_q;
    logic sample_valid_q;

    logic                  busy;
    logic                  cfg_prescale_ok;
    logic                  majority;
    logic [PRSC_WIDTH-1:0] edge_ext;
    logic [PRSC_WIDTH-1:0] half;
    logic [PRSC_WIDTH-1:0] pos_s0;
    logic [PRSC_WIDTH-1:0] pos_s1;
    logic [PRSC_WIDTH-1:0] pos_maj;

    assign busy = (state_q != StIdle);

    // Only the documented ratios are accepted; anything else falls back to 8.
    assign cfg_prescale_ok = (cfg_prescale == Presc8) ||
                             ((MAX_PRESCALE >= 16) && (cfg_prescale == Presc16)) ||
                             ((MAX_PRESCALE >= 32) && (cfg_prescale == Presc32));

    // -----------------------------------------------------------------------------------------
    // Mid-bit sampling: s0 at P/2-1, s1 at P/2, vote with the live line at P/2+1. The strobe
    // is registered so it is high during the cycle where edge_cnt = P/2+2.
    // -----------------------------------------------------------------------------------------
    assign edge_ext = {1'b0, edge_cnt};
    assign half     = prescale_q >> 1;
    assign pos_s0   = half - PRSC_WIDTH'(1);
    assign pos_s1   = half;
    assign pos_maj  = half + PRSC_WIDTH'(1);
    assign majority = (s0_q & s1_q) | (s0_q & rx_in) | (s1_q & rx_in);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_q           <= 1'b0;
            s1_q           <= 1'b0;
            sampled_bit_q  <= 1'b0;
            sample_valid_q <= 1'b0;
        end else begin
            if (busy && (edge_ext == pos_s0)) begin
                s0_q <= rx_in;
            end
            if (busy && (edge_ext == pos_s1)) begin
                s1_q <= rx_in;
            end
            if (busy && (edge_ext == pos_maj)) begin
                sampled_bit_q <= majority;
            end
            // Gated by busy so a counter that has not cleared yet after an exit cannot fire.
            sample_valid_q <= busy && (edge_ext == pos_maj);
        end
    end

    // -----------------------------------------------------------------------------------------
    // Frame FSM and datapath next-state
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = par_err_q;
        stp_err_d    = stp_err_q;
        prescale_d   = prescale_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;

        case (state_q)
            StIdle: begin
                if (!rx_in) begin
                    state_d    = StStart;
                    par_err_d  = 1'b0;
                    stp_err_d  = 1'b0;
                    prescale_d = cfg_prescale_ok ? cfg_prescale : Presc8;
                    par_en_d   = cfg_par_en;
                    par_typ_d  = cfg_par_typ;
                end
            end

            StStart: begin
                if (sample_valid_q && sampled_bit_q) begin
                    // Line went back high before mid-bit: glitch, not a start bit.
                    state_d = StIdle;
                end else if (edge_max && (bit_cnt == '0)) begin
                    state_d = StData;
                end
            end

            StData: begin
                if (sample_valid_q) begin
                    shift_d = {sampled_bit_q, shift_q[DATA_WIDTH-1:1]};
                end
                if (edge_max && (bit_cnt == BitCntLast)) begin
                    state_d = par_en_q ? StParity : StStop;
                end
            end

            StParity: begin
                if (sample_valid_q) begin
                    par_err_d = sampled_bit_q != (^shift_q ^ par_typ_q);
                end
                if (edge_max) begin
                    state_d = StStop;
                end
            end

            StStop: begin
                // Leave in the middle of the stop bit so a start bit right behind it is seen.
                if (sample_valid_q) begin
                    stp_err_d = ~sampled_bit_q;
                    if (!par_err_q && sampled_bit_q) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            prescale_q   <= Presc8;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
            prescale_q   <= prescale_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------------------------
    assign cnt_enable   = busy;
    assign rx_busy      = busy;
    assign cnt_prescale = prescale_q;
    assign cnt_par_en   = par_en_q;
    assign p_data       = p_data_q;
    assign data_valid   = data_valid_q;
    assign par_err      = par_err_q;
    assign stp_err      = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_uart_rx_ctrl
//
// Bench for uart_rx_ctrl. Contains a behavioural edge/bit counter to close the loop with the
// controller, a table of directed frames, randomized frames checked against a frame-level
// model, and hand-written sequences for start glitch and reset mid-frame.
// ---------------------------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    localparam int DW = 8;
    localparam int PW = 6;
    localparam int FW = 5;

    logic          clk;
    logic          rst;
    logic          rx_in;
    logic [PW-1:0] cfg_prescale;
    logic          cfg_par_en;
    logic          cfg_par_typ;
    logic [PW-2:0] edge_cnt;
    logic [FW-2:0] bit_cnt;
    logic          edge_max;
    logic          cnt_enable;
    logic [PW-1:0] cnt_prescale;
    logic          cnt_par_en;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;
    logic          rx_busy;

    uart_rx_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .rx_in        (rx_in),
        .cfg_prescale (cfg_prescale),
        .cfg_par_en   (cfg_par_en),
        .cfg_par_typ  (cfg_par_typ),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .edge_max     (edge_max),
        .cnt_enable   (cnt_enable),
        .cnt_prescale (cnt_prescale),
        .cnt_par_en   (cnt_par_en),
        .p_data       (p_data),
        .data_valid   (data_valid),
        .par_err      (par_err),
        .stp_err      (stp_err),
        .rx_busy      (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge/bit counter: counts while enabled, clears one clock after enable drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!cnt_enable) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if ({1'b0, edge_cnt} == cnt_prescale - 6'd1) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + 5'd1;
        end
    end
    assign edge_max = ({1'b0, edge_cnt} == cnt_prescale - 6'd1);

    int n_tests = 0;
    int n_fail  = 0;
    int got_pulses = 0;
    int exp_pulses = 0;
    logic [DW-1:0] exp_pdata = '0;

    always @(negedge clk) begin
        if (rst && data_valid) got_pulses <= got_pulses + 1;
    end

    typedef struct {
        logic [PW-1:0] cfg_p;
        logic          pe;
        logic          pt;
        logic [DW-1:0] data;
        logic          bad_par;
        logic          stop_bit;
        logic          b2b;
        logic          mid_change;
        logic          exp_valid;
        logic          exp_par_err;
        logic          exp_stp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int eff_p(input logic [PW-1:0] c);
        if (c == 6'd8 || c == 6'd16 || c == 6'd32) return int'(c);
        return 8;
    endfunction

    function automatic vec_t mk(input logic [PW-1:0] p, input logic pe, input logic pt,
                                input logic [DW-1:0] d, input logic bp, input logic sb,
                                input logic b2b, input logic mc, input logic ev,
                                input logic epe, input logic ese);
        vec_t v;
        v.cfg_p = p; v.pe = pe; v.pt = pt; v.data = d; v.bad_par = bp; v.stop_bit = sb;
        v.b2b = b2b; v.mid_change = mc;
        v.exp_valid = ev; v.exp_par_err = epe; v.exp_stp_err = ese;
        return v;
    endfunction

    // Frame-level model: count the ones the line carries over payload plus parity bit.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   ones;
        logic par_bit;
        r = v;
        par_bit = (v.pt ? ~^v.data : ^v.data) ^ v.bad_par;
        ones = $countones(v.data) + int'(par_bit);
        r.exp_par_err = v.pe && ((ones % 2) != int'(v.pt));
        r.exp_stp_err = !v.stop_bit;
        r.exp_valid   = !r.exp_par_err && v.stop_bit;
        return r;
    endfunction

    // Entered and left at a falling edge; the next rising edge after entry is E0.
    task automatic send_frame(input vec_t v, input string name);
        int   p;
        int   f;
        int   ns;
        int   n;
        int   len;
        logic cfg_bad;
        logic bits[$];
        logic par_bit;
        p  = eff_p(v.cfg_p);
        f  = v.pe ? 10 : 9;
        ns = f * p + p / 2 + 2;
        par_bit = (v.pt ? ~^v.data : ^v.data) ^ v.bad_par;
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(v.data[i]);
        if (v.pe) bits.push_back(par_bit);
        bits.push_back(v.stop_bit);
        cfg_prescale = v.cfg_p;
        cfg_par_en   = v.pe;
        cfg_par_typ  = v.pt;
        n = -1;
        cfg_bad = 1'b0;
        for (int k = 0; k < bits.size(); k++) begin
            rx_in = bits[k];
            len = (k == bits.size() - 1) ? p / 2 + 4 : p;
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                n++;
                if (n == 0) check({name, "_flags_clear_at_start"}, {30'd0, par_err, stp_err}, 0);
                if (n <= ns && (!rx_busy || cnt_par_en !== v.pe || cnt_prescale !== 6'(p)))
                    cfg_bad = 1'b1;
                if (v.mid_change && n == p + 3) begin
                    cfg_prescale = 6'($urandom);
                    cfg_par_en   = ~v.pe;
                    cfg_par_typ  = 1'($urandom);
                end
            end
        end
        // Now in cycle ns+1: results visible, controller idle.
        if (v.exp_valid) begin
            exp_pdata = v.data;
            exp_pulses++;
        end
        check({name, "_cfg_held"}, {31'd0, cfg_bad}, 0);
        check({name, "_data_valid"}, {31'd0, data_valid}, {31'd0, v.exp_valid});
        check({name, "_par_err"}, {31'd0, par_err}, {31'd0, v.exp_par_err});
        check({name, "_stp_err"}, {31'd0, stp_err}, {31'd0, v.exp_stp_err});
        check({name, "_p_data"}, {24'd0, p_data}, {24'd0, exp_pdata});
        check({name, "_idle"}, {31'd0, rx_busy}, 0);
        rx_in = 1'b1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [PW-1:0] plist [5];
        vec_t v;
        plist = '{6'd8, 6'd16, 6'd32, 6'd12, 6'd0};

        rst = 1'b0; rx_in = 1'b1;
        cfg_prescale = 6'd16; cfg_par_en = 1'b1; cfg_par_typ = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_cnt_enable", {31'd0, cnt_enable}, 0);
        check("reset_rx_busy", {31'd0, rx_busy}, 0);
        check("reset_outputs", {20'd0, data_valid, par_err, stp_err, cnt_par_en, p_data}, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        //          P      pe    pt    data   badp  stop  b2b   midc  valid perr  serr
        vecs.push_back(mk(6'd16, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(6'd8,  1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(6'd8,  1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(6'd32, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(6'd32, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(6'd16, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(6'd8,  1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(6'd16, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(6'd16, 1'b1, 1'b0, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(6'd12, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            send_frame(vecs[i], $sformatf("dir%0d", i));
            if (!vecs[i].b2b) repeat (3) @(negedge clk);
        end

        // Start glitch: low for 4 clocks at P=16, must abort at E11.
        cfg_prescale = 6'd16; cfg_par_en = 1'b0; cfg_par_typ = 1'b0;
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        repeat (7) @(negedge clk);
        check("glitch_busy_at_E10", {31'd0, rx_busy}, 1);
        @(negedge clk);
        check("glitch_idle_at_E11", {30'd0, rx_busy, cnt_enable}, 0);
        check("glitch_no_flags", {29'd0, par_err, stp_err, data_valid}, 0);
        repeat (4) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            v.cfg_p      = plist[$urandom_range(0, 4)];
            v.pe         = 1'($urandom);
            v.pt         = 1'($urandom);
            v.data       = 8'($urandom);
            v.bad_par    = v.pe && ($urandom_range(0, 3) == 0);
            v.stop_bit   = ($urandom_range(0, 4) != 0);
            v.b2b        = 1'($urandom);
            v.mid_change = 1'($urandom);
            v = model(v);
            send_frame(v, $sformatf("rnd%0d", i));
            if (!v.b2b) repeat ($urandom_range(1, 5)) @(negedge clk);
        end

        // Reset in the middle of DATA.
        cfg_prescale = 6'd16; cfg_par_en = 1'b1; cfg_par_typ = 1'b0;
        rx_in = 1'b0;
        repeat (16) @(negedge clk);
        rx_in = 1'b1;
        repeat (40) @(negedge clk);
        check("midreset_busy_before", {31'd0, rx_busy}, 1);
        rst = 1'b0;
        #1;
        check("midreset_outputs_zero",
              {19'd0, cnt_enable, rx_busy, data_valid, par_err, stp_err, p_data}, 0);
        check("midreset_cnt_par_en", {31'd0, cnt_par_en}, 0);
        exp_pdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(mk(6'd16, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0),
                   "after_reset");
        repeat (4) @(negedge clk);

        check("data_valid_pulse_count", got_pulses, exp_pulses);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
